imem_dump_reader: RTL and testbench
===================================

// Module: imem_dump_reader
// PURPOSE
//   Read-back counterpart of the instruction/data memory programming port. While the CPU is
//   halted (cpu_en=0), it reads a contiguous window of memory words and streams them out on a
//   valid/ready interface, tagged with their addresses. Used by benches and debug logic to dump
//   results such as the multiply product at address 2. A small FIFO absorbs the memory's
//   1-cycle read latency so that backpressure never loses a word.
// PARAMETERS
//   ADDR_W      11  memory address width (matches w_adrs)
//   DATA_W      32  memory word width (matches w_instruction)
//   FIFO_DEPTH  4   output buffer entries; power of 2, >=2
// PORTS
//   clk         in   1        system clock, rising edge
//   resetn      in   1        asynchronous active-low reset
//   cpu_en      in   1        CPU run enable; reads permitted only when 0
//   start       in   1        1-cycle request to begin a dump
//   base_adrs   in   ADDR_W   first address, sampled with an accepted start
//   word_count  in   ADDR_W+1 number of words to read, 0..2^ADDR_W, sampled with an accepted start
//   r_enable    out  1        memory read strobe
//   r_adrs      out  ADDR_W   memory read address
//   r_data      in   DATA_W   memory read data; valid the cycle after r_enable
//   out_valid   out  1        out_adrs/out_data hold a word
//   out_ready   in   1        consumer accepts the word when out_valid&&out_ready
//   out_adrs    out  ADDR_W   address of the presented word
//   out_data    out  DATA_W   presented word
//   busy        out  1        high in READ or DRAIN
//   done        out  1        1-cycle pulse when a dump completes normally
//   aborted     out  1        1-cycle pulse when a dump is cancelled by cpu_en
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, FIFO empty, in-flight flag cleared.
//   FSM: IDLE -> READ on start && !cpu_en. start is ignored when not IDLE or when cpu_en=1.
//        READ -> DRAIN when the last read is issued. DRAIN -> IDLE with done when FIFO is
//        empty and no read is in flight. If word_count=0, start goes IDLE -> IDLE with a done
//        pulse on the next cycle, and no read is issued.
//   Issue: r_enable=1 iff state READ && !cpu_en && remaining>0 &&
//          (fifo_count + inflight) < FIFO_DEPTH. r_adrs=base_adrs+i, i=0..count-1, modulo 2^ADDR_W,
//          so 0x7FF wraps to 0x000. The address counter and remaining count update on each issue.
//   Capture: the cycle after r_enable, r_data is pushed into the FIFO along with the issued address.
//            A push and a pop may happen in the same cycle; fifo_count is then unchanged.
//   Output: out_valid=!fifo_empty. Head data/address must stay stable until the handshake.
//           Sustained throughput is 1 word/cycle when out_ready=1. Latency is 2 cycles from
//           accepted start to the first out_valid (start, issue, capture).
//   Abort: cpu_en=1 while in READ or DRAIN stops issuing immediately, flushes the FIFO,
//          discards any in-flight word, clears out_valid on the next edge, pulses aborted,
//          and goes to IDLE. done is not pulsed.
//   done and aborted are never high in the same cycle. busy=0 in the cycle that done pulses.
//   Asynchronous reset mid-dump returns to IDLE immediately with no done or aborted pulse.
// TESTING
//   1 Reset with resetn=0 -> all outputs 0. After release with start=0 -> idle, r_enable=0.
//   2 Memory holds [0]=0000000d, [1]=0000000f, [2]=000000c3. start with base=0, count=3,
//     out_ready=1 -> words (0,d), (1,f), (2,c3) on consecutive cycles, then done one cycle later.
//   3 Same dump with out_ready toggled 1/0 each cycle -> all 3 words in order, none dropped
//     or duplicated, out_data stable while stalled, r_enable throttled when the FIFO is full.
//   4 base=0x7FE, count=4 -> out_adrs sequence 7FE, 7FF, 000, 001 with the matching data.
//   5 count=0 -> no r_enable, done pulses exactly once. start with cpu_en=1 -> ignored, busy stays 0.
//   6 count=16, out_ready=0, cpu_en raised after 3 cycles -> aborted pulses once,
//     out_valid=0 after, FSM in IDLE, and a new start works normally.

Source files
------------

// File: rtl/imem_dump_reader.sv
// Streams a contiguous window of memory words out on a valid/ready port while the CPU is halted.
// A small FIFO absorbs the memory's one-cycle read latency so backpressure never loses a word.
module imem_dump_reader #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_en,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_adrs,
    input  logic [ADDR_W:0]   word_count,
    output logic              r_enable,
    output logic [ADDR_W-1:0] r_adrs,
    input  logic [DATA_W-1:0] r_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_adrs,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] rd_adrs;
    logic [ADDR_W:0]   remaining;
    logic              inflight;
    logic [ADDR_W-1:0] cap_adrs;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_adrs [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_count;

    logic [PTR_W+1:0]  occupancy;
    logic              room;
    logic              issue;
    logic              push;
    logic              pop;
    logic              abort;
    logic              drain_empty;

    // Handshake: a word transfers on a rising edge where out_valid && out_ready; while
    // out_valid is high and out_ready low, out_adrs/out_data hold the same head entry.
    assign occupancy   = {1'b0, fifo_count} + {{(PTR_W + 1){1'b0}}, inflight};
    assign room        = occupancy < (PTR_W + 2)'(FIFO_DEPTH);
    assign issue       = (state == ST_READ) && !cpu_en && (remaining != '0) && room;
    assign push        = inflight;
    assign out_valid   = (fifo_count != '0);
    assign pop         = out_valid && out_ready;
    assign abort       = cpu_en && (state != ST_IDLE);
    // Fifo empties on this edge if nothing is in flight and the last entry leaves now.
    assign drain_empty = !inflight &&
                         ((fifo_count == '0) || ((fifo_count == (PTR_W + 1)'(1)) && pop));

    assign r_enable  = issue;
    assign r_adrs    = rd_adrs;
    assign out_adrs  = out_valid ? fifo_adrs[rd_ptr] : '0;
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (push && !abort) begin
            fifo_data[wr_ptr] <= r_data;
            fifo_adrs[wr_ptr] <= cap_adrs;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            rd_adrs    <= '0;
            remaining  <= '0;
            inflight   <= 1'b0;
            cap_adrs   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done     <= 1'b0;
            aborted  <= 1'b0;
            inflight <= issue;
            if (issue) begin
                cap_adrs  <= rd_adrs;
                rd_adrs   <= rd_adrs + ADDR_W'(1);
                remaining <= remaining - (ADDR_W + 1)'(1);
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase

            case (state)
                ST_IDLE: begin
                    if (start && !cpu_en) begin
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= ST_READ;
                            rd_adrs   <= base_adrs;
                            remaining <= word_count;
                        end
                    end
                end
                ST_READ: begin
                    if (issue && (remaining == (ADDR_W + 1)'(1))) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Cancellation overrides everything above: drop buffered and in-flight words.
            if (abort) begin
                state      <= ST_IDLE;
                done       <= 1'b0;
                aborted    <= 1'b1;
                inflight   <= 1'b0;
                remaining  <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_dump_reader.sv
// Directed bench for imem_dump_reader: a behavioural one-cycle-latency memory feeds the reader
// and each scenario task checks the streamed words against hand-computed expectations.
module tb_imem_dump_reader;

    logic        clk;
    logic        resetn;
    logic        cpu_en;
    logic        start;
    logic [10:0] base_adrs;
    logic [11:0] word_count;
    logic        r_enable;
    logic [10:0] r_adrs;
    logic [31:0] r_data;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_adrs;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:2047];
    logic [42:0] exp_q[$];
    int          tests_run;
    int          tests_failed;

    imem_dump_reader dut (
        .clk        (clk),
        .resetn     (resetn),
        .cpu_en     (cpu_en),
        .start      (start),
        .base_adrs  (base_adrs),
        .word_count (word_count),
        .r_enable   (r_enable),
        .r_adrs     (r_adrs),
        .r_data     (r_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_adrs   (out_adrs),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .dbg_state  (dbg_state)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial r_data = '0;
    always @(posedge clk) begin
        if (r_enable) r_data <= mem[r_adrs];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns at the sample point of the first cycle after the accepting edge.
    task automatic start_dump(input logic [10:0] base, input logic [11:0] count);
        base_adrs  = base;
        word_count = count;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({r_enable, out_valid, busy, done, aborted} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 00000", {r_enable, out_valid, busy, done, aborted});
        end
        tests_run++;
        if ({r_adrs, out_adrs, out_data, dbg_state} !== '0) begin
            tests_failed++;
            $display("FAIL reset_buses: got r_adrs=%h out_adrs=%h out_data=%h state=%0d want all 0",
                     r_adrs, out_adrs, out_data, dbg_state);
        end
        resetn = 1'b1;
        tick();
        tick();
        tick();
        tests_run++;
        if ({r_enable, busy, dbg_state} !== 4'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got r_enable=%b busy=%b state=%0d want 0 0 0",
                     r_enable, busy, dbg_state);
        end
    endtask

    task automatic test_basic();
        logic [42:0] exp_w [3];
        exp_w[0] = {11'h000, 32'h0000_000d};
        exp_w[1] = {11'h001, 32'h0000_000f};
        exp_w[2] = {11'h002, 32'h0000_00c3};
        out_ready = 1'b1;
        start_dump(11'h000, 12'd3);
        for (int k = 1; k <= 7; k++) begin
            tests_run++;
            if (r_enable !== (k <= 3)) begin
                tests_failed++;
                $display("FAIL basic_r_enable k=%0d: got %b want %b", k, r_enable, (k <= 3));
            end
            if (k <= 3) begin
                tests_run++;
                if (r_adrs !== 11'(k - 1)) begin
                    tests_failed++;
                    $display("FAIL basic_r_adrs k=%0d: got %h want %h", k, r_adrs, 11'(k - 1));
                end
            end
            tests_run++;
            if (out_valid !== (k >= 3 && k <= 5)) begin
                tests_failed++;
                $display("FAIL basic_out_valid k=%0d: got %b want %b", k, out_valid, (k >= 3 && k <= 5));
            end
            if (k >= 3 && k <= 5) begin
                tests_run++;
                if ({out_adrs, out_data} !== exp_w[k-3]) begin
                    tests_failed++;
                    $display("FAIL basic_word k=%0d: got %h want %h", k, {out_adrs, out_data}, exp_w[k-3]);
                end
            end
            tests_run++;
            if (done !== (k == 6)) begin
                tests_failed++;
                $display("FAIL basic_done k=%0d: got %b want %b", k, done, (k == 6));
            end
            tests_run++;
            if (busy !== (k <= 5)) begin
                tests_failed++;
                $display("FAIL basic_busy k=%0d: got %b want %b", k, busy, (k <= 5));
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [42:0] prev_w;
        logic [42:0] got_w;
        logic        held;
        logic        seen_done;
        int          issued;
        int          accepted;
        held = 1'b0;
        seen_done = 1'b0;
        issued = 0;
        accepted = 0;
        prev_w = '0;
        exp_q.push_back({11'h000, 32'h0000_000d});
        exp_q.push_back({11'h001, 32'h0000_000f});
        exp_q.push_back({11'h002, 32'h0000_00c3});
        out_ready = 1'b0;
        start_dump(11'h000, 12'd3);
        for (int k = 1; k <= 40 && !seen_done; k++) begin
            got_w = {out_adrs, out_data};
            if (r_enable) begin
                tests_run++;
                if (issued - accepted >= 4) begin
                    tests_failed++;
                    $display("FAIL stall_throttle k=%0d: got outstanding %0d want < 4", k, issued - accepted);
                end
                issued++;
            end
            if (held) begin
                tests_run++;
                if (!out_valid || got_w !== prev_w) begin
                    tests_failed++;
                    $display("FAIL stall_hold k=%0d: got valid=%b word=%h want valid=1 word=%h",
                             k, out_valid, got_w, prev_w);
                end
            end
            out_ready = ~out_ready;
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL stall_extra_word: got %h want no word", got_w);
                end else begin
                    prev_w = exp_q.pop_front();
                    if (got_w !== prev_w) begin
                        tests_failed++;
                        $display("FAIL stall_word: got %h want %h", got_w, prev_w);
                    end
                end
                accepted++;
                held = 1'b0;
            end else begin
                held = out_valid;
                prev_w = got_w;
            end
            if (done) seen_done = 1'b1;
            tick();
        end
        tests_run++;
        if (!seen_done || accepted != 3) begin
            tests_failed++;
            $display("FAIL stall_complete: got done=%b words=%0d want done=1 words=3", seen_done, accepted);
        end
        exp_q.delete();
    endtask

    task automatic test_wrap();
        logic [42:0] w;
        logic        seen_done;
        seen_done = 1'b0;
        exp_q.push_back({11'h7FE, 32'hA000_07FE});
        exp_q.push_back({11'h7FF, 32'hA000_07FF});
        exp_q.push_back({11'h000, 32'h0000_000d});
        exp_q.push_back({11'h001, 32'h0000_000f});
        out_ready = 1'b1;
        start_dump(11'h7FE, 12'd4);
        for (int k = 1; k <= 30 && !seen_done; k++) begin
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL wrap_extra_word: got %h want no word", {out_adrs, out_data});
                end else begin
                    w = exp_q.pop_front();
                    if ({out_adrs, out_data} !== w) begin
                        tests_failed++;
                        $display("FAIL wrap_word: got %h want %h", {out_adrs, out_data}, w);
                    end
                end
            end
            if (done) seen_done = 1'b1;
            tick();
        end
        tests_run++;
        if (!seen_done || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL wrap_complete: got done=%b missing=%0d want done=1 missing=0", seen_done, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_fifo_full();
        logic [42:0] w;
        logic        seen_done;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back({11'(16 + i), 32'hA000_0010 + 32'(i)});
        out_ready = 1'b0;
        start_dump(11'h010, 12'd8);
        for (int k = 1; k <= 6; k++) begin
            tests_run++;
            if (r_enable !== (k <= 4)) begin
                tests_failed++;
                $display("FAIL full_r_enable k=%0d: got %b want %b", k, r_enable, (k <= 4));
            end
            if (k < 6) tick();
        end
        tests_run++;
        if (!out_valid || {out_adrs, out_data} !== {11'h010, 32'hA000_0010}) begin
            tests_failed++;
            $display("FAIL full_head: got valid=%b word=%h want valid=1 word=%h",
                     out_valid, {out_adrs, out_data}, {11'h010, 32'hA000_0010});
        end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && !seen_done; k++) begin
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL full_extra_word: got %h want no word", {out_adrs, out_data});
                end else begin
                    w = exp_q.pop_front();
                    if ({out_adrs, out_data} !== w) begin
                        tests_failed++;
                        $display("FAIL full_word: got %h want %h", {out_adrs, out_data}, w);
                    end
                end
            end
            if (done) seen_done = 1'b1;
            tick();
        end
        tests_run++;
        if (!seen_done || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL full_complete: got done=%b missing=%0d want done=1 missing=0", seen_done, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_zero_and_ignored();
        int done_cnt;
        int re_cnt;
        int busy_cnt;
        done_cnt = 0;
        re_cnt = 0;
        busy_cnt = 0;
        out_ready = 1'b1;
        start_dump(11'h005, 12'd0);
        for (int k = 1; k <= 5; k++) begin
            done_cnt += int'(done);
            re_cnt   += int'(r_enable);
            busy_cnt += int'(busy);
            tick();
        end
        tests_run++;
        if (done_cnt != 1 || re_cnt != 0 || busy_cnt != 0) begin
            tests_failed++;
            $display("FAIL zero_count: got done=%0d r_enable=%0d busy=%0d want 1 0 0", done_cnt, re_cnt, busy_cnt);
        end
        done_cnt = 0;
        re_cnt = 0;
        busy_cnt = 0;
        cpu_en = 1'b1;
        start_dump(11'h000, 12'd3);
        for (int k = 1; k <= 5; k++) begin
            done_cnt += int'(done);
            re_cnt   += int'(r_enable);
            busy_cnt += int'(busy);
            tick();
        end
        tests_run++;
        if (done_cnt != 0 || re_cnt != 0 || busy_cnt != 0 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL ignored_start: got done=%0d r_enable=%0d busy=%0d state=%0d want 0 0 0 0",
                     done_cnt, re_cnt, busy_cnt, dbg_state);
        end
        cpu_en = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic [42:0] w;
        logic        seen_done;
        int          abort_cnt;
        int          valid_cnt;
        int          done_cnt;
        abort_cnt = 0;
        valid_cnt = 0;
        done_cnt = 0;
        out_ready = 1'b0;
        start_dump(11'h000, 12'd16);
        tick();
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_pre: got valid=%b busy=%b want 1 1", out_valid, busy);
        end
        cpu_en = 1'b1;
        tick();
        tests_run++;
        if ({aborted, out_valid, busy, done, r_enable, dbg_state} !== {5'b10000, 2'd0}) begin
            tests_failed++;
            $display("FAIL abort_edge: got aborted=%b valid=%b busy=%b done=%b r_enable=%b state=%0d want 1 0 0 0 0 0",
                     aborted, out_valid, busy, done, r_enable, dbg_state);
        end
        for (int k = 0; k < 5; k++) begin
            abort_cnt += int'(aborted);
            valid_cnt += int'(out_valid);
            done_cnt  += int'(done);
            if (k == 1) cpu_en = 1'b0;
            tick();
        end
        tests_run++;
        if (abort_cnt != 1 || valid_cnt != 0 || done_cnt != 0) begin
            tests_failed++;
            $display("FAIL abort_after: got aborted=%0d valid=%0d done=%0d want 1 0 0", abort_cnt, valid_cnt, done_cnt);
        end
        seen_done = 1'b0;
        exp_q.push_back({11'h000, 32'h0000_000d});
        exp_q.push_back({11'h001, 32'h0000_000f});
        exp_q.push_back({11'h002, 32'h0000_00c3});
        out_ready = 1'b1;
        start_dump(11'h000, 12'd3);
        for (int k = 1; k <= 30 && !seen_done; k++) begin
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL restart_extra_word: got %h want no word", {out_adrs, out_data});
                end else begin
                    w = exp_q.pop_front();
                    if ({out_adrs, out_data} !== w) begin
                        tests_failed++;
                        $display("FAIL restart_word: got %h want %h", {out_adrs, out_data}, w);
                    end
                end
            end
            if (done) seen_done = 1'b1;
            tick();
        end
        tests_run++;
        if (!seen_done || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL restart_complete: got done=%b missing=%0d want done=1 missing=0", seen_done, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 1'b0;
        cpu_en       = 1'b0;
        start        = 1'b0;
        base_adrs    = '0;
        word_count   = '0;
        out_ready    = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'h0000_000d;
        mem[1] = 32'h0000_000f;
        mem[2] = 32'h0000_00c3;

        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_fifo_full();
        test_zero_and_ignored();
        test_abort();

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
